// File: rtl/hazard_pkg.sv
// Shared defaults, derived widths and types for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int NREGS_DEF     = 32;
  localparam int MAX_LAT_DEF   = 3;

  localparam int REG_W = $clog2(NREGS_DEF);
  localparam int LAT_W = $clog2(MAX_LAT_DEF + 1);

  localparam int LANE_IXU1 = 0;
  localparam int LANE_IXU2 = 1;
  localparam int LANE_LSU  = 2;
  localparam int LANE_BRU  = 3;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One architectural register's pending-write countdown: load on issue, count down to zero.
module hazard_sb_entry #(
  parameter int LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // NOTE: every branch assigns cnt_d after a default, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)               cnt_d = '0;
    else if (set)            cnt_d = set_lat;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state uses non-blocking assignment; the async clear guarantees no entry survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: raises a bundle-wide RAW stall against pending
// long-latency writes from any lane and counts stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_LANES = NUM_LANES_DEF,
  parameter  int NREGS     = NREGS_DEF,
  parameter  int MAX_LAT   = MAX_LAT_DEF,
  parameter  int CNT_W     = 32,
  localparam int REG_BITS  = $clog2(NREGS),
  localparam int LAT_BITS  = $clog2(MAX_LAT + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dc_valid,
  input  logic [NUM_LANES*2*REG_BITS-1:0] dc_rs,
  input  logic [NUM_LANES*2-1:0]          dc_rs_used,
  input  logic [NUM_LANES*REG_BITS-1:0]   dc_rd,
  input  logic [NUM_LANES*LAT_BITS-1:0]   dc_rd_lat,
  input  logic                            ext_stall,
  input  logic                            flush,
  input  logic                            perf_clr,
  output logic                            stall_out,
  output logic                            issue_fire,
  output logic [NREGS-1:0]                busy_mask,
  output logic [CNT_W-1:0]                stall_cycles
);

  logic [LAT_BITS-1:0] cnt_arr     [NREGS];
  logic [LAT_BITS-1:0] set_lat_arr [NREGS];
  logic [NREGS-1:0]    set_vec;
  logic                hazard_hit;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

  assign cnt_arr[0]   = '0;
  assign busy_mask[0] = 1'b0;

  // Register 0 is never loaded; keep its decode slots visibly sunk.
  logic unused_zero;
  assign unused_zero = ^{set_vec[0], set_lat_arr[0]};

  always_comb begin
    hazard_hit = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < 2; s++) begin
        if (dc_rs_used[l*2+s] && (dc_rs[(l*2+s)*REG_BITS +: REG_BITS] != '0) &&
            (cnt_arr[dc_rs[(l*2+s)*REG_BITS +: REG_BITS]] != '0))
          hazard_hit = 1'b1;
      end
    end
  end

  assign stall_out  = dc_valid & hazard_hit;
  assign issue_fire = dc_valid & ~stall_out & ~ext_stall;

  // Ascending lane scan: a later lane writing the same rd overwrites an earlier one.
  always_comb begin
    set_vec = '0;
    for (int r = 0; r < NREGS; r++) set_lat_arr[r] = '0;
    if (issue_fire) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if ((dc_rd[l*REG_BITS +: REG_BITS] != '0) && (dc_rd_lat[l*LAT_BITS +: LAT_BITS] != '0)) begin
          set_vec[dc_rd[l*REG_BITS +: REG_BITS]] = 1'b1;
          set_lat_arr[dc_rd[l*REG_BITS +: REG_BITS]] =
            (dc_rd_lat[l*LAT_BITS +: LAT_BITS] > LAT_BITS'(MAX_LAT)) ?
              LAT_BITS'(MAX_LAT) : dc_rd_lat[l*LAT_BITS +: LAT_BITS];
        end
      end
    end
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W (LAT_BITS)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .set     (set_vec[r]),
      .set_lat (set_lat_arr[r]),
      .cnt     (cnt_arr[r]),
      .busy    (busy_mask[r])
    );
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr)
      stall_cycles_d = '0;
    else if (stall_out && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard, checked against a countdown model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NL   = 4;
  localparam int NR   = 32;
  localparam int ML   = 3;
  localparam int CW   = 4;
  localparam int RW   = 5;
  localparam int LW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic dc_valid, ext_stall, flush, perf_clr;
  logic [NL*2*RW-1:0] dc_rs;
  logic [NL*2-1:0]    dc_rs_used;
  logic [NL*RW-1:0]   dc_rd;
  logic [NL*LW-1:0]   dc_rd_lat;
  logic               stall_out, issue_fire;
  logic [NR-1:0]      busy_mask;
  logic [CW-1:0]      stall_cycles;

  // Bench-side bundle description, packed onto the DUT buses below.
  int t_rs   [NL][2];
  int t_used [NL][2];
  int t_rd   [NL];
  int t_lat  [NL];

  // Reference model: remaining cycles per register and the stall counter.
  int m_cnt [NR];
  int m_stalls;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    dc_rs = '0; dc_rs_used = '0; dc_rd = '0; dc_rd_lat = '0;
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < 2; s++) begin
        dc_rs[(l*2+s)*RW +: RW] = RW'(t_rs[l][s]);
        dc_rs_used[l*2+s]       = (t_used[l][s] != 0);
      end
      dc_rd[l*RW +: RW]     = RW'(t_rd[l]);
      dc_rd_lat[l*LW +: LW] = LW'(t_lat[l]);
    end
  end

  hazard_scoreboard #(
    .NUM_LANES (NL),
    .NREGS     (NR),
    .MAX_LAT   (ML),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dc_valid     (dc_valid),
    .dc_rs        (dc_rs),
    .dc_rs_used   (dc_rs_used),
    .dc_rd        (dc_rd),
    .dc_rd_lat    (dc_rd_lat),
    .ext_stall    (ext_stall),
    .flush        (flush),
    .perf_clr     (perf_clr),
    .stall_out    (stall_out),
    .issue_fire   (issue_fire),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dc_valid = 1'b0; ext_stall = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    for (int l = 0; l < NL; l++) begin
      t_rd[l] = 0; t_lat[l] = 0;
      for (int s = 0; s < 2; s++) begin t_rs[l][s] = 0; t_used[l][s] = 0; end
    end
  endtask

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b;
    for (int r = 0; r < NR; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic bit model_stall();
    bit h = 0;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < 2; s++)
        if (t_used[l][s] != 0 && t_rs[l][s] != 0 && m_cnt[t_rs[l][s]] != 0) h = 1;
    return dc_valid && h;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_stalls = 0;
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check state.
  task automatic cycle(input string tag);
    bit e_stall, e_fire;
    int nxt [NR];
    #1;
    e_stall = model_stall();
    e_fire  = dc_valid && !e_stall && !ext_stall;
    check({tag, ".stall"}, 64'(stall_out), 64'(e_stall));
    check({tag, ".fire"},  64'(issue_fire), 64'(e_fire));
    check({tag, ".busy"},  64'(busy_mask), 64'(model_busy()));
    @(posedge clk);
    for (int r = 0; r < NR; r++) nxt[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    if (e_fire)
      for (int l = 0; l < NL; l++)
        if (t_rd[l] != 0 && t_lat[l] != 0) nxt[t_rd[l]] = (t_lat[l] > ML) ? ML : t_lat[l];
    if (flush)
      for (int r = 0; r < NR; r++) nxt[r] = 0;
    m_cnt = nxt;
    if (perf_clr)                     m_stalls = 0;
    else if (e_stall && m_stalls < CMAX) m_stalls++;
    #1;
    check({tag, ".cycles"}, 64'(stall_cycles), 64'(m_stalls));
    check({tag, ".busy_q"}, 64'(busy_mask), 64'(model_busy()));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset.busy",   64'(busy_mask), 64'(0));
    check("reset.stall",  64'(stall_out), 64'(0));
    check("reset.cycles", 64'(stall_cycles), 64'(0));
    check("reset.fire",   64'(issue_fire), 64'(dc_valid && !ext_stall));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls_seen;
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc_valid = 1'b1;
    #1;
    check("por.busy",   64'(busy_mask), 64'(0));
    check("por.stall",  64'(stall_out), 64'(0));
    check("por.fire",   64'(issue_fire), 64'(1));
    check("por.cycles", 64'(stall_cycles), 64'(0));
    @(posedge clk);
    model_reset();
    #1;

    // Load-use: one bubble.
    idle(); dc_valid = 1; t_rd[LANE_LSU] = 5; t_lat[LANE_LSU] = 1;
    cycle("lu_issue");
    idle(); dc_valid = 1; t_rs[LANE_IXU1][0] = 5; t_used[LANE_IXU1][0] = 1;
    cycle("lu_stall");
    cycle("lu_go");
    check("lu.total", 64'(stall_cycles), 64'(1));

    // Multi-cycle with ext_stall overlapping the first two stall cycles.
    idle(); dc_valid = 1; t_rd[LANE_IXU1] = 7; t_lat[LANE_IXU1] = 3;
    cycle("mc_issue");
    idle(); dc_valid = 1; t_rs[LANE_BRU][1] = 7; t_used[LANE_BRU][1] = 1;
    stalls_seen = 0;
    for (int i = 0; i < 10; i++) begin
      ext_stall = (i < 2);
      #1;
      if (issue_fire) break;
      if (stall_out) stalls_seen++;
      cycle("mc_wait");
    end
    check("mc.fire", 64'(issue_fire), 64'(1));
    check("mc.stall_count", 64'(stalls_seen), 64'(3));
    cycle("mc_go");

    // Zero register never becomes busy; unused source is ignored.
    idle(); dc_valid = 1; t_rd[LANE_IXU2] = 0; t_lat[LANE_IXU2] = 3;
    cycle("zr_issue");
    check("zr.busy", 64'(busy_mask), 64'(0));
    idle(); dc_valid = 1; t_rd[LANE_IXU2] = 9; t_lat[LANE_IXU2] = 3;
    cycle("un_issue");
    idle();
    cycle("un_idle");
    dc_valid = 1; t_rs[LANE_IXU1][1] = 9; t_used[LANE_IXU1][1] = 0;
    #1;
    check("un.stall", 64'(stall_out), 64'(0));
    check("un.fire",  64'(issue_fire), 64'(1));
    cycle("un_read");
    idle();
    repeat (2) cycle("un_drain");

    // Same-rd in two lanes: higher lane wins; re-issue overrides decrement.
    idle(); dc_valid = 1;
    t_rd[0] = 4; t_lat[0] = 1; t_rd[2] = 4; t_lat[2] = 3;
    cycle("sr_issue");
    idle();
    repeat (2) cycle("sr_dec");
    check("sr.busy4", 64'(busy_mask[4]), 64'(1));
    dc_valid = 1; t_rd[LANE_LSU] = 4; t_lat[LANE_LSU] = 2;
    cycle("sr_reissue");
    idle();
    cycle("sr_dec2");
    check("sr.still_busy", 64'(busy_mask[4]), 64'(1));
    cycle("sr_dec3");
    check("sr.done", 64'(busy_mask[4]), 64'(0));

    // Flush with a stalled dependent.
    idle(); dc_valid = 1; t_rd[LANE_LSU] = 6; t_lat[LANE_LSU] = 3;
    cycle("fl_issue");
    idle(); dc_valid = 1; t_rs[LANE_IXU2][0] = 6; t_used[LANE_IXU2][0] = 1;
    cycle("fl_stall");
    flush = 1;
    cycle("fl_flush");
    flush = 0;
    #1;
    check("fl.stall", 64'(stall_out), 64'(0));
    check("fl.busy",  64'(busy_mask), 64'(0));
    cycle("fl_after");

    // Reset mid-countdown.
    idle(); dc_valid = 1; t_rd[LANE_LSU] = 6; t_lat[LANE_LSU] = 3;
    cycle("rs_issue");
    idle(); dc_valid = 1; t_rs[LANE_IXU2][0] = 6; t_used[LANE_IXU2][0] = 1;
    cycle("rs_stall");
    async_reset();

    // Counter saturation and clear-wins.
    for (int k = 0; k < 6; k++) begin
      idle(); dc_valid = 1; t_rd[LANE_LSU] = 10; t_lat[LANE_LSU] = 3;
      cycle("ct_issue");
      idle(); dc_valid = 1; t_rs[LANE_IXU1][0] = 10; t_used[LANE_IXU1][0] = 1;
      repeat (4) cycle("ct_dep");
    end
    check("ct.saturated", 64'(stall_cycles), 64'(CMAX));
    idle(); dc_valid = 1; t_rd[LANE_LSU] = 11; t_lat[LANE_LSU] = 3;
    cycle("pc_issue");
    idle(); dc_valid = 1; t_rs[LANE_BRU][0] = 11; t_used[LANE_BRU][0] = 1; perf_clr = 1;
    cycle("pc_clr");
    check("pc.cleared", 64'(stall_cycles), 64'(0));
    perf_clr = 0;
    repeat (2) cycle("pc_dep");

    // Randomized bundles over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      idle();
      dc_valid  = ($urandom_range(3) != 0);
      ext_stall = ($urandom_range(3) == 0);
      flush     = ($urandom_range(15) == 0);
      perf_clr  = ($urandom_range(15) == 0);
      for (int l = 0; l < NL; l++) begin
        t_rd[l]  = $urandom_range(7);
        t_lat[l] = $urandom_range(ML);
        for (int s = 0; s < 2; s++) begin
          t_rs[l][s]   = $urandom_range(7);
          t_used[l][s] = ($urandom_range(3) == 0);
        end
      end
      cycle("rnd");
    end

    idle();
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
